// File: rtl/ddfs_pkg.sv
// Shared types, constants and saturating Q2.30 step helpers for the envelope generator.
package ddfs_pkg;

    localparam int unsigned ACC_W = 32;
    localparam int unsigned ENV_W = 16;

    localparam logic [ACC_W-1:0] ENV_MAX_Q30 = 32'h4000_0000;
    localparam logic [ENV_W-1:0] ENV_MAX_Q14 = 16'h4000;

    typedef enum logic [2:0] {
        ADSR_IDLE    = 3'd0,
        ADSR_ATTACK  = 3'd1,
        ADSR_DECAY   = 3'd2,
        ADSR_SUSTAIN = 3'd3,
        ADSR_RELEASE = 3'd4
    } adsr_state_t;

    // a + b computed one bit wider, clipped at +1.0
    function automatic logic [ACC_W-1:0] sat_add_q30(input logic [ACC_W-1:0] a,
                                                     input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, ENV_MAX_Q30}) begin
            return ENV_MAX_Q30;
        end
        return s[ACC_W-1:0];
    endfunction

    // a - b, clipped at floor; the comparison a <= floor + b is done one bit wider
    function automatic logic [ACC_W-1:0] sat_sub_q30(input logic [ACC_W-1:0] a,
                                                     input logic [ACC_W-1:0] b,
                                                     input logic [ACC_W-1:0] floor);
        logic [ACC_W:0] lim;
        lim = {1'b0, floor} + {1'b0, b};
        if ({1'b0, a} <= lim) begin
            return floor;
        end
        return a - b;
    endfunction

endpackage

// File: rtl/adsr_env.sv
// ADSR envelope generator: Q2.30 accumulator driven by a tick-gated FSM, Q2.14 output.
module adsr_env
    import ddfs_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_W,
    parameter int unsigned ENV_WIDTH = ENV_W
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick_i,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [ACC_WIDTH-1:0] attack_step,
    input  logic [ACC_WIDTH-1:0] decay_step,
    input  logic [ENV_WIDTH-1:0] sus_level,
    input  logic [ACC_WIDTH-1:0] release_step,
    output logic [ENV_WIDTH-1:0] env_o,
    output logic [2:0]           state_o,
    output logic                 idle_o
);

    adsr_state_t          state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ENV_WIDTH-1:0] sus_clamped;
    logic [ACC_WIDTH-1:0] sus_q30;
    logic [ACC_WIDTH-1:0] nxt;

    // Sustain target, clamped to +1.0 and widened to Q2.30
    always_comb begin
        sus_clamped = (sus_level > ENV_MAX_Q14) ? ENV_MAX_Q14 : sus_level;
        sus_q30     = {sus_clamped, {(ACC_WIDTH-ENV_WIDTH){1'b0}}};
    end

    // State and accumulator registers, asynchronously cleared
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ADSR_IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    // Next state / accumulator: start beats stop beats tick; control edges leave acc alone
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        nxt     = '0;
        if (start_i) begin
            state_d = ADSR_ATTACK;
        end else if (stop_i) begin
            if (state_q == ADSR_ATTACK || state_q == ADSR_DECAY || state_q == ADSR_SUSTAIN) begin
                state_d = ADSR_RELEASE;
            end
        end else if (tick_i) begin
            unique case (state_q)
                ADSR_IDLE: begin
                    acc_d = '0;
                end
                ADSR_ATTACK: begin
                    // saturation to MAX coincides exactly with acc + step >= MAX
                    nxt   = sat_add_q30(acc_q, attack_step);
                    acc_d = nxt;
                    if (attack_step == '0 || nxt == ENV_MAX_Q30) begin
                        acc_d   = ENV_MAX_Q30;
                        state_d = ADSR_DECAY;
                    end
                end
                ADSR_DECAY: begin
                    // landing on SUS coincides exactly with acc <= SUS + step
                    nxt   = sat_sub_q30(acc_q, decay_step, sus_q30);
                    acc_d = nxt;
                    if (decay_step == '0 || nxt == sus_q30) begin
                        acc_d   = sus_q30;
                        state_d = ADSR_SUSTAIN;
                    end
                end
                ADSR_SUSTAIN: begin
                    acc_d = sus_q30;
                end
                ADSR_RELEASE: begin
                    nxt   = sat_sub_q30(acc_q, release_step, '0);
                    acc_d = nxt;
                    if (release_step == '0 || nxt == '0) begin
                        acc_d   = '0;
                        state_d = ADSR_IDLE;
                    end
                end
                default: begin
                    acc_d   = '0;
                    state_d = ADSR_IDLE;
                end
            endcase
        end
    end

    assign env_o   = acc_q[ACC_WIDTH-1 -: ENV_WIDTH];
    assign state_o = state_q;
    assign idle_o  = (state_q == ADSR_IDLE);

endmodule
